// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } db_state_t;

    localparam int DEBOUNCE_DEFAULT = 100000;

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability counter, level FSM and
// registered rise/fall pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic btn_db_o,
    output logic btn_rise_o,
    output logic btn_fall_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic          s1_q, s2_q;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // State, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= CNT_ZERO;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= btn_raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: a check is aborted by any sample matching the current level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s2_q) begin
                    state_d = ST_CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_CHK_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_CHK_LOW: begin
                if (s2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = CNT_ZERO;
                db_d    = 1'b0;
            end
        endcase
    end

    assign btn_db_o   = db_q;
    assign btn_rise_o = rise_q;
    assign btn_fall_o = fall_q;

endmodule : btn_debounce_ch

// File: rtl/btn_debouncer.sv
// Debounces N_BTN independent push-button channels feeding FPGA_led_switch.
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw_i (btn_raw[gi]),
            .btn_db_o  (btn_db[gi]),
            .btn_rise_o(btn_rise[gi]),
            .btn_fall_o(btn_fall[gi])
        );
    end

endmodule : btn_debouncer

// File: tb/tb_btn_debouncer.sv
// Randomised plus directed bench for btn_debouncer against a sliding-window
// reference model built from the raw input history.
module tb_btn_debouncer;

    localparam int NB    = 4;
    localparam int DC    = 4;
    localparam int MAXE  = 4096;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_db;
    logic [NB-1:0] btn_rise;
    logic [NB-1:0] btn_fall;

    int n_checks;
    int n_fail;

    logic [NB-1:0] raw_h [0:MAXE-1];
    bit            rst_h [0:MAXE-1];
    int            e;
    logic [NB-1:0] m_db, m_rise, m_fall;

    btn_debouncer #(.N_BTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %b expected %b", tag, e, act, exp);
        end
    endtask

    // Level the debounce logic sees at edge idx: raw from two edges earlier,
    // forced to 0 if reset hit either synchroniser stage.
    function automatic logic seen(input int idx, input int ch);
        if (idx < 2) return 1'b0;
        if (rst_h[idx-1] || rst_h[idx-2]) return 1'b0;
        return raw_h[idx-2][ch];
    endfunction

    // Reference model: a channel takes a new level once its last DC seen
    // samples (all since the last reset) agree on a value differing from it.
    always @(posedge clk) begin
        logic [NB-1:0] nd;
        if (e < MAXE) begin
            raw_h[e] = btn_raw;
            rst_h[e] = rst;
            if (rst) begin
                m_db = '0; m_rise = '0; m_fall = '0;
            end else begin
                nd = m_db;
                for (int ch = 0; ch < NB; ch++) begin
                    logic v;
                    bit ok;
                    v  = seen(e, ch);
                    ok = (e - DC + 1) >= 0;
                    for (int j = 0; j < DC; j++) begin
                        if (!ok) break;
                        if (rst_h[e-j] || seen(e-j, ch) != v) ok = 0;
                    end
                    if (ok && v != m_db[ch]) nd[ch] = v;
                end
                m_rise = nd & ~m_db;
                m_fall = m_db & ~nd;
                m_db   = nd;
            end
        end
        e++;
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (e > 0 && e <= MAXE) begin
            check_eq("db",   btn_db,   m_db);
            check_eq("rise", btn_rise, m_rise);
            check_eq("fall", btn_fall, m_fall);
            check_eq("excl", btn_rise & btn_fall, 4'b0000);
        end
    end

    task automatic hold(input logic [NB-1:0] v, input int n);
        btn_raw = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        e        = 0;
        m_db     = '0;
        m_rise   = '0;
        m_fall   = '0;
        rst      = 1'b1;
        btn_raw  = 4'b1111;

        // Reset with buttons held, then release.
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        hold(4'b1111, 10);
        check_eq("rst_rel_db", btn_db, 4'b1111);
        hold(4'b0000, 10);
        check_eq("release_db", btn_db, 4'b0000);

        // Clean press, glitch rejection, minimal accepted pulse.
        hold(4'b0001, 10);
        hold(4'b0000, 10);
        hold(4'b0100, 3);
        hold(4'b0000, 10);
        hold(4'b0100, 4);
        hold(4'b0000, 12);

        // Bounce on channel 1.
        hold(4'b0010, 1); hold(4'b0000, 1);
        hold(4'b0010, 1); hold(4'b0000, 1);
        hold(4'b0010, 10);
        hold(4'b0000, 10);

        // Simultaneous rise and fall across channels.
        hold(4'b0101, 10);
        hold(4'b1010, 10);
        check_eq("simul_db", btn_db, 4'b1010);
        hold(4'b0000, 10);

        // Reset in the middle of a check.
        hold(4'b1000, 3);
        rst = 1'b1;
        hold(4'b1000, 1);
        rst = 1'b0;
        hold(4'b1000, 10);
        hold(4'b0000, 10);

        // Random bouncing with occasional resets.
        for (int i = 0; i < 1800; i++) begin
            if ($urandom_range(0, 4) == 0) btn_raw = btn_raw ^ NB'($urandom_range(1, 15));
            rst = ($urandom_range(0, 249) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        hold(4'b0000, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_btn_debouncer
